nand_response_checker: RTL and testbench

Response-checking end of the NAND gate test flow: it consumes (a, b, y) samples taken from a NAND gate under test, compares each y against the expected NAND of a and b, and counts vectors and mismatches. It runs a fixed-length check sequence under a start/valid/ready handshake and reports a pass/fail verdict. It sits beside the stimulus generator in the gate-level self-test harness and closes the loop that the stimulus side opens.

---
 rtl/nand_response_checker.sv | 174 +++++++++++++++++
 tb/tb_nand_response_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_response_checker.sv
// nand_response_checker
//   Response checker for a NAND gate under test. Each accepted sample
//   (in_a, in_b, in_y) is compared against ~(in_a & in_b). The checker
//   counts accepted samples and mismatches over a run of NUM_VECTORS
//   samples, then reports a pass/fail verdict.
//
// Optional build macro:
//   NAND_CHK_COVERAGE_EN  when defined, pass also requires that all four
//                         {a,b} combinations were seen (cov_mask == 4'b1111).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (honoured in IDLE or DONE)
//   in_valid        sample present on in_a/in_b/in_y
//   in_a, in_b      gate inputs applied for the sample
//   in_y            gate output observed for the sample
//   in_ready        checker accepts a sample this cycle (state RUN)
//   busy            run in progress
//   done            run complete, held until the next start or rst
//   pass            verdict, valid only while done=1
//   vec_count       samples accepted in the current run
//   err_count       mismatches in the current run, saturating
//   first_fail      {a,b} of the first mismatch, 2'b00 if none
//   fail_seen       at least one mismatch in the current run
//   cov_mask        bit {a,b} set once that combination was accepted
//
// States:
//   IDLE | after reset, waiting for start
//   RUN  | accepting samples until NUM_VECTORS have been taken
//   DONE | verdict presented, counters held, waiting for start

module nand_response_checker #(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_y,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       first_fail,
  output logic             fail_seen,
  output logic [3:0]       cov_mask
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] vec_count_q, vec_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic [1:0]       first_fail_q, first_fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic [3:0]       cov_mask_q, cov_mask_d;

  logic             accept;
  logic             mismatch;
  logic             verdict_ok;

  // in_ready_q is exactly (state_q == RUN), so it qualifies acceptance.
  assign accept   = in_ready_q & in_valid;
  assign mismatch = in_y != ~(in_a & in_b);

  always_comb begin
    state_d      = state_q;
    vec_count_d  = vec_count_q;
    err_count_d  = err_count_q;
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    cov_mask_d   = cov_mask_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = RUN;
          vec_count_d  = '0;
          err_count_d  = '0;
          first_fail_d = 2'b00;
          fail_seen_d  = 1'b0;
          cov_mask_d   = 4'b0000;
        end
      end
      RUN: begin
        if (accept) begin
          vec_count_d             = vec_count_q + 1'b1;
          cov_mask_d[{in_a, in_b}] = 1'b1;
          if (mismatch) begin
            if (err_count_q != CNT_MAX) begin
              err_count_d = err_count_q + 1'b1;
            end
            // Only the first mismatch of a run is captured.
            if (!fail_seen_q) begin
              fail_seen_d  = 1'b1;
              first_fail_d = {in_a, in_b};
            end
          end
          if (vec_count_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered: decode from the next state so they line up
  // with state_q after the edge.
  always_comb begin
`ifdef NAND_CHK_COVERAGE_EN
    verdict_ok = (err_count_d == '0) && (cov_mask_d == 4'b1111);
`else
    verdict_ok = (err_count_d == '0);
`endif
    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN);
    done_d     = (state_d == DONE);
    pass_d     = (state_d == DONE) && verdict_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      vec_count_q  <= '0;
      err_count_q  <= '0;
      first_fail_q <= 2'b00;
      fail_seen_q  <= 1'b0;
      cov_mask_q   <= 4'b0000;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      vec_count_q  <= vec_count_d;
      err_count_q  <= err_count_d;
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
      cov_mask_q   <= cov_mask_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign vec_count  = vec_count_q;
  assign err_count  = err_count_q;
  assign first_fail = first_fail_q;
  assign fail_seen  = fail_seen_q;
  assign cov_mask   = cov_mask_q;

endmodule

// File: tb/tb_nand_response_checker.sv
module tb_nand_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, in_valid, in_a, in_b, in_y;
  logic       in_ready, busy, done, pass, fail_seen;
  logic [7:0] vec_count, err_count;
  logic [1:0] first_fail;
  logic [3:0] cov_mask;

  logic       s_start, s_valid, s_a, s_b, s_y;
  logic       s_ready, s_busy, s_done, s_pass, s_fail_seen;
  logic [1:0] s_vec, s_err, s_first_fail;
  logic [3:0] s_cov;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nand_response_checker #(.NUM_VECTORS(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_y(in_y), .in_ready(in_ready),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
    .err_count(err_count), .first_fail(first_fail),
    .fail_seen(fail_seen), .cov_mask(cov_mask)
  );

  nand_response_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid),
    .in_a(s_a), .in_b(s_b), .in_y(s_y), .in_ready(s_ready),
    .busy(s_busy), .done(s_done), .pass(s_pass), .vec_count(s_vec),
    .err_count(s_err), .first_fail(s_first_fail),
    .fail_seen(s_fail_seen), .cov_mask(s_cov)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one sample {a,b,y} with in_valid=1 and advance one edge.
  task automatic sample(input logic a, input logic b, input logic y);
    in_valid = 1'b1; in_a = a; in_b = b; in_y = y;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic s_sample(input logic a, input logic b, input logic y);
    s_valid = 1'b1; s_a = a; s_b = b; s_y = y;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {7'd0, in_ready}, 8'd0);
    chk({tag, "_busy"},  {7'd0, busy},     8'd0);
    chk({tag, "_done"},  {7'd0, done},     8'd0);
    chk({tag, "_pass"},  {7'd0, pass},     8'd0);
    chk({tag, "_vec"},   vec_count,        8'd0);
    chk({tag, "_err"},   err_count,        8'd0);
    chk({tag, "_ff"},    {6'd0, first_fail}, 8'd0);
    chk({tag, "_fs"},    {7'd0, fail_seen},  8'd0);
    chk({tag, "_cov"},   {4'd0, cov_mask},   8'd0);
  endtask

  initial begin
    logic exp_cov_pass;
`ifdef NAND_CHK_COVERAGE_EN
    exp_cov_pass = 1'b0;
`else
    exp_cov_pass = 1'b1;
`endif
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; in_y = 1'b0;
    s_start = 1'b0; s_valid = 1'b0; s_a = 1'b0; s_b = 1'b0; s_y = 1'b0;
    tick();
    tick();
    chk_zero("reset");
    chk("reset_small_err", {6'd0, s_err}, 8'd0);
    rst = 1'b0;
    tick();

    // Run 1: all four combinations, all correct.
    start = 1'b1; tick(); start = 1'b0;
    chk("r1_busy",  {7'd0, busy},     8'd1);
    chk("r1_ready", {7'd0, in_ready}, 8'd1);
    sample(0, 0, 1);
    sample(0, 1, 1);
    sample(1, 0, 1);
    chk("r1_done_early", {7'd0, done}, 8'd0);
    chk("r1_vec3",       vec_count,    8'd3);
    sample(1, 1, 0);
    chk("r1_done",  {7'd0, done},     8'd1);
    chk("r1_busy0", {7'd0, busy},     8'd0);
    chk("r1_ready0",{7'd0, in_ready}, 8'd0);
    chk("r1_vec",   vec_count,        8'd4);
    chk("r1_err",   err_count,        8'd0);
    chk("r1_cov",   {4'd0, cov_mask}, 8'hf);
    chk("r1_pass",  {7'd0, pass},     8'd1);
    chk("r1_ff",    {6'd0, first_fail}, 8'd0);
    tick();
    chk("r1_hold_done", {7'd0, done}, 8'd1);

    // Run 2: second sample wrong (01 -> y=0), started from DONE.
    start = 1'b1; tick(); start = 1'b0;
    chk("r2_clr_vec", vec_count, 8'd0);
    chk("r2_clr_cov", {4'd0, cov_mask}, 8'd0);
    chk("r2_done0",   {7'd0, done}, 8'd0);
    chk("r2_pass0",   {7'd0, pass}, 8'd0);
    sample(0, 0, 1);
    sample(0, 1, 0);
    sample(1, 0, 1);
    sample(1, 1, 0);
    chk("r2_done", {7'd0, done},        8'd1);
    chk("r2_err",  err_count,           8'd1);
    chk("r2_fs",   {7'd0, fail_seen},   8'd1);
    chk("r2_ff",   {6'd0, first_fail},  8'd1);
    chk("r2_pass", {7'd0, pass},        8'd0);

    // Run 3: 001 four times; verdict depends on coverage build option.
    start = 1'b1; tick(); start = 1'b0;
    chk("r3_clr_fs", {7'd0, fail_seen},  8'd0);
    chk("r3_clr_ff", {6'd0, first_fail}, 8'd0);
    chk("r3_clr_err", err_count, 8'd0);
    repeat (4) sample(0, 0, 1);
    chk("r3_done", {7'd0, done},      8'd1);
    chk("r3_err",  err_count,         8'd0);
    chk("r3_cov",  {4'd0, cov_mask},  8'h1);
    chk("r3_pass", {7'd0, pass},      {7'd0, exp_cov_pass});

    // Run 4: idle gaps plus a start pulse mid-run.
    start = 1'b1; tick(); start = 1'b0;
    sample(0, 0, 1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("r4_vec_gap", vec_count, 8'd1);
    chk("r4_busy",    {7'd0, busy}, 8'd1);
    sample(0, 1, 1);
    sample(1, 0, 1);
    chk("r4_done_early", {7'd0, done}, 8'd0);
    sample(1, 1, 0);
    chk("r4_done", {7'd0, done}, 8'd1);
    chk("r4_vec",  vec_count,    8'd4);
    chk("r4_pass", {7'd0, pass}, 8'd1);
    // Sample offered in DONE must be dropped.
    sample(1, 1, 1);
    chk("r4_drop_vec", vec_count, 8'd4);
    chk("r4_drop_err", err_count, 8'd0);
    chk("r4_drop_fs",  {7'd0, fail_seen}, 8'd0);

    // Run 5: reset mid-run (with start and a sample present), then full run.
    start = 1'b1; tick(); start = 1'b0;
    sample(0, 0, 0);
    sample(0, 1, 1);
    chk("r5_vec2", vec_count, 8'd2);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_a = 1'b1; in_b = 1'b1; in_y = 1'b1;
    tick();
    chk_zero("r5_rst");
    rst = 1'b0;
    // start and a sample in the same IDLE cycle: sample not taken.
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("r5_idle_vec",  vec_count,    8'd0);
    chk("r5_idle_busy", {7'd0, busy}, 8'd1);
    chk("r5_idle_cov",  {4'd0, cov_mask}, 8'd0);
    sample(1, 1, 0);
    sample(1, 0, 1);
    sample(0, 1, 0);
    sample(0, 0, 0);
    chk("r5_done", {7'd0, done},       8'd1);
    chk("r5_vec",  vec_count,          8'd4);
    chk("r5_err",  err_count,          8'd2);
    chk("r5_ff",   {6'd0, first_fail}, 8'd1);
    chk("r5_cov",  {4'd0, cov_mask},   8'hf);
    chk("r5_pass", {7'd0, pass},       8'd0);

    // Small instance: CNT_W=2, NUM_VECTORS=3, every sample wrong.
    s_start = 1'b1; tick(); s_start = 1'b0;
    s_sample(0, 0, 0);
    s_sample(1, 1, 1);
    s_sample(1, 0, 0);
    chk("s_done", {7'd0, s_done}, 8'd1);
    chk("s_err",  {6'd0, s_err},  8'd3);
    chk("s_vec",  {6'd0, s_vec},  8'd3);
    chk("s_ff",   {6'd0, s_first_fail}, 8'd0);
    chk("s_pass", {7'd0, s_pass}, 8'd0);
    s_start = 1'b1; tick(); s_start = 1'b0;
    chk("s_clr_err", {6'd0, s_err}, 8'd0);
    chk("s_clr_fs",  {7'd0, s_fail_seen}, 8'd0);
    s_sample(0, 1, 0);
    chk("s_err1", {6'd0, s_err}, 8'd1);
    chk("s_ff1",  {6'd0, s_first_fail}, 8'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
